rc5_key_schedule: RTL and testbench
===================================

Name: rc5_key_schedule

Overview:
- RC5 key-expansion stage. Sits directly upstream of the RC5 cipher/decipher datapath and fills the round-key table S[0..T-1] from a B-byte secret key.
- Runs the standard three phases: load L from the key bytes, initialise S with PW/QW, then the 3*max(T,C) mixing loop.
- Exposes a registered S-table read port that the cipher/decipher rounds consume once done is high.

Parameters:
- W, 32, word width in bits; power of 2, 16..64.
- B, 16, key length in bytes, 1..255.
- R, 12, number of rounds.
- PW, 32'hB7E15163, magic constant P (W bits).
- QW, 32'h9E3779B9, magic constant Q (W bits).
- U, W/8, derived; bytes per word.
- C, max(1, ceil(B/U)), derived; L length.
- T, 2*R+2, derived; S length.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse; starts expansion when sampled in IDLE.
- iKey  in  8*B  secret key; byte k = iKey[8*k+:8]; sampled on the start edge.
- iS_addr  in  ceil(log2 T)  S-table read address.
- oS_data  out  W  S[iS_addr]; registered, one-cycle latency.
- oBusy  out  1  high from the start edge until done.
- oDone  out  1  high while a valid table is held; level signal.

Behaviour:
- Reset (async) values:
  - FSM goes to IDLE.
  - oBusy=0, oDone=0, oS_data=0.
  - All S, L words and the i, j, A, B, counters are cleared to 0.
- States:
  - IDLE -> LOAD_L -> INIT_S -> MIX -> DONE.
  - DONE -> LOAD_L on a new iStart (rekey).
- Start:
  - iStart is accepted only in IDLE or DONE. It is ignored in every other state.
  - On the accepting edge: latch iKey, clear L, oBusy<=1, oDone<=0, k<=B-1.
- LOAD_L: B cycles, one byte per cycle, k descending from B-1 to 0.
  - L[k/U] <= (L[k/U] << 8) + key[k], truncated to W bits.
- INIT_S: T cycles, i = 0..T-1.
  - S[0] <= PW; S[i] <= S[i-1] + QW (mod 2^W).
- MIX: N = 3*max(T,C) iterations, one per cycle. A, B, i, j start at 0.
  - Anew = S[i] <= rotl(S[i] + A + B, 3).
  - Bnew = L[j] <= rotl(L[j] + Anew + B, (Anew + B) mod W).
  - i <= (i+1) mod T; j <= (j+1) mod C.
  - All adds are mod 2^W. The rotate amount uses the low log2(W) bits of the sum.
- DONE: oDone=1, oBusy=0. The table is held until the next start or rst.
- Latency: oDone rises exactly B+T+N+1 edges after the start edge. With the defaults this is 16+26+78+1 = 121.
- Read port:
  - oS_data <= S[iS_addr] every edge, in any state.
  - Reads are only meaningful while oDone=1.
  - An address >= T returns 0.
- Reset mid-operation: all state is cleared immediately. No partial table is ever flagged valid.
- Rekey from DONE: oDone drops on the accepting edge. Readers must stall until oDone returns.
- iKey changes after the start edge have no effect on the run in progress.

Decomposition:
- Shared package rc5_pkg holds:
  - PW/QW constants for W = 16/32/64.
  - The T and C derivation functions.
  - The log2 helper.
  - The FSM state encoding.
- One sub-module: rc5_rotl, a combinational W-bit left barrel rotator with amount input log2(W) bits. It is instantiated twice (constant 3 and variable amount) and is reusable by the cipher/decipher rounds.

Test Plan:
- Reset then read: assert rst mid-run, then read any address -> oS_data=0, oDone=0, oBusy=0 immediately; no oDone pulse follows.
- Zero key, defaults, pulse iStart -> oBusy high for 120 cycles and oDone rises at edge 121. Chain this table into the cipher with plaintext A=0, B=0 -> ciphertext A=EEDBA521, B=6D8F4B15.
- Key 128'h91CEA91001A5556351B241BE19465F91, plaintext A=EEDBA521, B=6D8F4B15 -> cipher output A=AC13C0F7, B=52892B5B. The decipher run on that output returns the original plaintext.
- iStart pulsed again at cycle 50 of a run -> ignored; oDone still at edge 121 and the table is identical to the single-start run.
- Rekey from DONE with a different key -> oDone drops on the start edge and returns 121 cycles later. S[0] differs from the previous table, and the decipher round-trip is still correct.
- Read address T (26) while oDone=1 -> oS_data=0 one cycle later. Sweep addresses 0..25 -> each value appears exactly one cycle after its address.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 blocks: magic constants, size derivations,
// the log2 helper and the key-schedule FSM encoding.
package rc5_pkg;

  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
  localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int v);
    return (log2c(v) < 1) ? 1 : log2c(v);
  endfunction

  function automatic int calc_t(input int rounds);
    return 2 * rounds + 2;
  endfunction

  function automatic int calc_c(input int key_bytes, input int word_bits);
    int u;
    int c;
    u = word_bits / 8;
    c = (key_bytes + u - 1) / u;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int calc_n(input int t, input int c);
    return 3 * ((t > c) ? t : c);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_L,
    ST_INIT_S,
    ST_MIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rc5_rotl.sv
// Combinational W-bit left rotator built as a log2(W)-stage barrel shifter;
// shared by the key schedule and the cipher rounds.
module rc5_rotl
  import rc5_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]          din,
  input  logic [log2c(W)-1:0]   amt,
  output logic [W-1:0]          dout
);

  localparam int LW = log2c(W);

  logic [W-1:0] stage [LW+1];

  assign stage[0] = din;

  for (genvar g = 0; g < LW; g++) begin : g_stage
    localparam int SH = 1 << g;
    assign stage[g+1] = amt[g] ? {stage[g][W-SH-1:0], stage[g][W-1 -: SH]} : stage[g];
  end

  assign dout = stage[LW];

endmodule

// File: rtl/rc5_key_schedule.sv
// RC5 key expansion: loads L from the key, seeds S with PW/QW, then runs the
// 3*max(T,C) mixing loop; the finished S table is read through a registered port.
module rc5_key_schedule
  import rc5_pkg::*;
#(
  parameter int          W  = 32,
  parameter int          B  = 16,
  parameter int          R  = 12,
  parameter logic [W-1:0] PW = P32,
  parameter logic [W-1:0] QW = Q32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iStart,
  input  logic [8*B-1:0]                iKey,
  input  logic [idx_w(calc_t(R))-1:0]   iS_addr,
  output logic [W-1:0]                  oS_data,
  output logic                          oBusy,
  output logic                          oDone
);

  localparam int U  = W / 8;
  localparam int UB = log2c(U);
  localparam int LW = log2c(W);
  localparam int T  = calc_t(R);
  localparam int C  = calc_c(B, W);
  localparam int N  = calc_n(T, C);
  localparam int AW = idx_w(T);
  localparam int KW = idx_w(B);
  localparam int JW = idx_w(C);
  localparam int NW = idx_w(N);

  localparam logic [AW-1:0] I_LAST = AW'(T - 1);
  localparam logic [JW-1:0] J_LAST = JW'(C - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  state_t state;
  state_t next_state;
  logic   start_accept;

  logic [8*B-1:0] key_q;
  logic [W-1:0]   s_mem [T];
  logic [W-1:0]   l_mem [C];
  logic [KW-1:0]  k;
  logic [AW-1:0]  i;
  logic [JW-1:0]  j;
  logic [NW-1:0]  n;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   init_val;

  logic [JW-1:0]  l_idx;
  logic [7:0]     key_byte;
  logic [W-1:0]   s_sum;
  logic [W-1:0]   a_new;
  logic [W-1:0]   sum_ab;
  logic [W-1:0]   l_sum;
  logic [W-1:0]   b_new;

  assign l_idx    = JW'(k >> UB);
  assign key_byte = key_q[8*k +: 8];

  // One mixing step: A from S[i], then B from L[j] rotated by (A+B).
  assign s_sum  = s_mem[i] + a_reg + b_reg;
  assign sum_ab = a_new + b_reg;
  assign l_sum  = l_mem[j] + sum_ab;

  rc5_rotl #(.W(W)) u_rotl_a (
    .din  (s_sum),
    .amt  (LW'(3)),
    .dout (a_new)
  );

  rc5_rotl #(.W(W)) u_rotl_b (
    .din  (l_sum),
    .amt  (sum_ab[LW-1:0]),
    .dout (b_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          next_state   = ST_LOAD_L;
          start_accept = 1'b1;
        end
      end
      ST_LOAD_L: if (k == '0)     next_state = ST_INIT_S;
      ST_INIT_S: if (i == I_LAST) next_state = ST_MIX;
      ST_MIX:    if (n == N_LAST) next_state = ST_DONE;
      ST_DONE: begin
        if (iStart) begin
          next_state   = ST_LOAD_L;
          start_accept = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath; oDone follows one edge after DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int x = 0; x < T; x++) s_mem[x] <= '0;
      for (int x = 0; x < C; x++) l_mem[x] <= '0;
      key_q    <= '0;
      k        <= '0;
      i        <= '0;
      j        <= '0;
      n        <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      init_val <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oS_data  <= '0;
    end else begin
      oS_data <= (int'(iS_addr) < T) ? s_mem[iS_addr] : '0;
      if (start_accept) begin
        key_q <= iKey;
        for (int x = 0; x < C; x++) l_mem[x] <= '0;
        k     <= KW'(B - 1);
        oBusy <= 1'b1;
        oDone <= 1'b0;
      end else begin
        case (state)
          ST_LOAD_L: begin
            l_mem[l_idx] <= (l_mem[l_idx] << 8) + W'(key_byte);
            if (k == '0) begin
              i        <= '0;
              init_val <= PW;
            end else begin
              k <= k - 1'b1;
            end
          end
          ST_INIT_S: begin
            s_mem[i] <= init_val;
            init_val <= init_val + QW;
            if (i == I_LAST) begin
              i     <= '0;
              j     <= '0;
              n     <= '0;
              a_reg <= '0;
              b_reg <= '0;
            end else begin
              i <= i + 1'b1;
            end
          end
          ST_MIX: begin
            s_mem[i] <= a_new;
            l_mem[j] <= b_new;
            a_reg    <= a_new;
            b_reg    <= b_new;
            i        <= (i == I_LAST) ? '0 : i + 1'b1;
            j        <= (j == J_LAST) ? '0 : j + 1'b1;
            n        <= n + 1'b1;
          end
          ST_DONE: begin
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc5_key_schedule.sv
// Self-checking bench for rc5_key_schedule (RC5-32/12/16): compares the table
// against a behavioural expansion model and known cipher vectors.
module tb_rc5_key_schedule;

  localparam int TT = 26;
  localparam logic [31:0] PWC = 32'hB7E15163;
  localparam logic [31:0] QWC = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst;
  logic         iStart;
  logic [127:0] iKey;
  logic [4:0]   iS_addr;
  logic [31:0]  oS_data;
  logic         oBusy;
  logic         oDone;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_tbl [TT];
  logic [31:0] dut_tbl   [TT];

  rc5_key_schedule dut (
    .clk     (clk),
    .rst     (rst),
    .iStart  (iStart),
    .iKey    (iKey),
    .iS_addr (iS_addr),
    .oS_data (oS_data),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int s);
    int t;
    t = s % 32;
    if (t == 0) return x;
    return (x << t) | (x >> (32 - t));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int s);
    int t;
    t = s % 32;
    if (t == 0) return x;
    return (x >> t) | (x << (32 - t));
  endfunction

  // Textbook RC5 key expansion on plain arrays.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] l [4];
    logic [31:0] a, b;
    int ii, jj;
    for (int x = 0; x < 4; x++) l[x] = 32'h0;
    for (int k = 15; k >= 0; k--) l[k/4] = (l[k/4] << 8) + {24'h0, key[8*k +: 8]};
    model_tbl[0] = PWC;
    for (int x = 1; x < TT; x++) model_tbl[x] = model_tbl[x-1] + QWC;
    a = 0; b = 0; ii = 0; jj = 0;
    for (int s = 0; s < 3 * TT; s++) begin
      a = rotl32(model_tbl[ii] + a + b, 3);
      model_tbl[ii] = a;
      b = rotl32(l[jj] + a + b, int'((a + b) & 32'd31));
      l[jj] = b;
      ii = (ii + 1) % TT;
      jj = (jj + 1) % 4;
    end
  endtask

  task automatic encrypt(input logic [31:0] pa, input logic [31:0] pb,
                         output logic [31:0] ca, output logic [31:0] cb);
    logic [31:0] a, b;
    a = pa + dut_tbl[0];
    b = pb + dut_tbl[1];
    for (int r = 1; r <= 12; r++) begin
      a = rotl32(a ^ b, int'(b[4:0])) + dut_tbl[2*r];
      b = rotl32(b ^ a, int'(a[4:0])) + dut_tbl[2*r+1];
    end
    ca = a;
    cb = b;
  endtask

  task automatic decrypt(input logic [31:0] ca, input logic [31:0] cb,
                         output logic [31:0] pa, output logic [31:0] pb);
    logic [31:0] a, b;
    a = ca;
    b = cb;
    for (int r = 12; r >= 1; r--) begin
      b = rotr32(b - dut_tbl[2*r+1], int'(a[4:0])) ^ a;
      a = rotr32(a - dut_tbl[2*r], int'(b[4:0])) ^ b;
    end
    pb = b - dut_tbl[1];
    pa = a - dut_tbl[0];
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues a one-edge iStart pulse; returns #1 after the accepting edge.
  task automatic start_run(input logic [127:0] key);
    @(posedge clk); #1;
    iKey   = key;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    iKey   = rand_key();
  endtask

  // Counts edges after the start edge until oDone; -1 if the bound expires.
  task automatic wait_done(input int pulse_at, input logic [127:0] pulse_key,
                           output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (c == pulse_at) begin
        iStart = 1'b1;
        iKey   = pulse_key;
      end else begin
        iStart = 1'b0;
      end
      if (oDone) begin
        lat = c;
        break;
      end
      if (!oBusy) busy_ok = 1'b0;
    end
    iStart = 1'b0;
  endtask

  task automatic read_table();
    for (int a = 0; a < TT; a++) begin
      iS_addr = 5'(a);
      @(posedge clk); #1;
      dut_tbl[a] = oS_data;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oS_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b data=%h, want 0 0 0", oBusy, oDone, oS_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, want 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_zero_key();
    int lat;
    bit busy_ok;
    int bad;
    logic [31:0] ca, cb;
    start_run(128'h0);
    checks++;
    if (oBusy !== 1'b1 || oDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_edge_flags: busy=%b done=%b, want 1 0", oBusy, oDone);
    end
    wait_done(0, 128'h0, lat, busy_ok);
    checks++;
    if (lat !== 121) begin
      errors++;
      $display("[TB] FAIL zero_key_latency: got %0d, want 121", lat);
    end
    checks++;
    if (!busy_ok || oBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_key_busy: busy_ok=%b busy_at_done=%b, want 1 0", busy_ok, oBusy);
    end
    read_table();
    model_expand(128'h0);
    bad = 0;
    for (int a = 0; a < TT; a++) if (dut_tbl[a] !== model_tbl[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL zero_key_table: %0d words differ, S0 got %h want %h", bad, dut_tbl[0], model_tbl[0]);
    end
    encrypt(32'h0, 32'h0, ca, cb);
    checks++;
    if (ca !== 32'hEEDBA521 || cb !== 32'h6D8F4B15) begin
      errors++;
      $display("[TB] FAIL zero_key_cipher: got %h %h, want EEDBA521 6D8F4B15", ca, cb);
    end
  endtask

  task automatic test_known_vector();
    int lat;
    bit busy_ok;
    logic [31:0] ca, cb, pa, pb;
    start_run(128'h91CEA91001A5556351B241BE19465F91);
    wait_done(0, 128'h0, lat, busy_ok);
    checks++;
    if (lat !== 121 || !busy_ok) begin
      errors++;
      $display("[TB] FAIL vector_latency: got %0d busy_ok=%b, want 121 1", lat, busy_ok);
    end
    read_table();
    encrypt(32'hEEDBA521, 32'h6D8F4B15, ca, cb);
    checks++;
    if (ca !== 32'hAC13C0F7 || cb !== 32'h52892B5B) begin
      errors++;
      $display("[TB] FAIL vector_cipher: got %h %h, want AC13C0F7 52892B5B", ca, cb);
    end
    decrypt(ca, cb, pa, pb);
    checks++;
    if (pa !== 32'hEEDBA521 || pb !== 32'h6D8F4B15) begin
      errors++;
      $display("[TB] FAIL vector_decipher: got %h %h, want EEDBA521 6D8F4B15", pa, pb);
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    bit busy_ok;
    int bad;
    logic [127:0] key;
    key = rand_key();
    start_run(key);
    wait_done(50, rand_key(), lat, busy_ok);
    checks++;
    if (lat !== 121 || !busy_ok) begin
      errors++;
      $display("[TB] FAIL ignored_start_latency: got %0d busy_ok=%b, want 121 1", lat, busy_ok);
    end
    read_table();
    model_expand(key);
    bad = 0;
    for (int a = 0; a < TT; a++) if (dut_tbl[a] !== model_tbl[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL ignored_start_table: %0d words differ", bad);
    end
  endtask

  task automatic test_rekey();
    int lat;
    bit busy_ok;
    int bad;
    logic [31:0] prev_s0, pa, pb, ca, cb, ra, rb;
    logic [127:0] key;
    prev_s0 = dut_tbl[0];
    key = rand_key();
    start_run(key);
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rekey_start_edge: done=%b busy=%b, want 0 1", oDone, oBusy);
    end
    wait_done(0, 128'h0, lat, busy_ok);
    checks++;
    if (lat !== 121 || !busy_ok) begin
      errors++;
      $display("[TB] FAIL rekey_latency: got %0d busy_ok=%b, want 121 1", lat, busy_ok);
    end
    read_table();
    checks++;
    if (dut_tbl[0] === prev_s0) begin
      errors++;
      $display("[TB] FAIL rekey_s0_changed: got %h, previous %h", dut_tbl[0], prev_s0);
    end
    model_expand(key);
    bad = 0;
    for (int a = 0; a < TT; a++) if (dut_tbl[a] !== model_tbl[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL rekey_table: %0d words differ", bad);
    end
    pa = $urandom;
    pb = $urandom;
    encrypt(pa, pb, ca, cb);
    decrypt(ca, cb, ra, rb);
    checks++;
    if (ra !== pa || rb !== pb) begin
      errors++;
      $display("[TB] FAIL rekey_roundtrip: got %h %h, want %h %h", ra, rb, pa, pb);
    end
  endtask

  // Relies on model_tbl matching the table currently held by the DUT.
  task automatic test_read_port();
    iS_addr = 5'd26;
    @(posedge clk); #1;
    checks++;
    if (oS_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read_addr_26: got %h, want 0", oS_data);
    end
    iS_addr = 5'd31;
    @(posedge clk); #1;
    checks++;
    if (oS_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read_addr_31: got %h, want 0", oS_data);
    end
    iS_addr = 5'd0;
    for (int a = 0; a < TT; a++) begin
      @(posedge clk); #1;
      checks++;
      if (oS_data !== model_tbl[a]) begin
        errors++;
        $display("[TB] FAIL sweep_addr_%0d: got %h, want %h", a, oS_data, model_tbl[a]);
      end
      if (a < TT - 1) begin
        iS_addr = 5'(a + 1);
        #1;
        checks++;
        if (oS_data !== model_tbl[a]) begin
          errors++;
          $display("[TB] FAIL sweep_hold_%0d: got %h, want %h", a, oS_data, model_tbl[a]);
        end
      end
    end
  endtask

  task automatic test_random_keys();
    int lat;
    bit busy_ok;
    int bad;
    logic [127:0] key;
    for (int r = 0; r < 3; r++) begin
      key = rand_key();
      start_run(key);
      wait_done(0, 128'h0, lat, busy_ok);
      checks++;
      if (lat !== 121) begin
        errors++;
        $display("[TB] FAIL random_latency_%0d: got %0d, want 121", r, lat);
      end
      read_table();
      model_expand(key);
      bad = 0;
      for (int a = 0; a < TT; a++) if (dut_tbl[a] !== model_tbl[a]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL random_table_%0d: %0d words differ, key %h", r, bad, key);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    int nonzero;
    start_run(rand_key());
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oS_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: done=%b busy=%b data=%h, want 0 0 0", oDone, oBusy, oS_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (oDone !== 1'b0 || oBusy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL mid_reset_no_done: done/busy became active after reset");
    end
    read_table();
    nonzero = 0;
    for (int a = 0; a < TT; a++) if (dut_tbl[a] !== 32'h0) nonzero++;
    checks++;
    if (nonzero != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_table_cleared: %0d words nonzero, want 0", nonzero);
    end
  endtask

  initial begin
    rst     = 1'b1;
    iStart  = 1'b0;
    iKey    = 128'h0;
    iS_addr = 5'd0;
    test_reset();
    test_zero_key();
    test_known_vector();
    test_ignored_start();
    test_rekey();
    test_read_port();
    test_random_keys();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
